// File: rtl/aes_spi_scheduler.sv
// Round-robin scheduler sharing one SPI-attached AES core between encrypt and decrypt requesters.
// Sends {data,key} MSB-first, idles through a compute gap with CS held, then shifts back 128 result bits.
//
//   state  | meaning
//   IDLE   | arbitrate enc/dec requests, latch frame of the winner
//   TX     | shift FRAME bits out on mosi, one per sclk period
//   WAIT   | CS held low, sclk quiet, for WAIT_CYC sclk periods
//   RX     | sample 128 miso bits on sclk rising edges
//   DONE   | release CS, publish result, pulse done
module aes_spi_scheduler #(
    parameter int NK       = 4,
    parameter int DIV      = 2,
    parameter int WAIT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enc_req,
    input  logic [127:0]       enc_data,
    input  logic [NK*32-1:0]   enc_key,
    output logic               enc_ack,
    output logic               enc_done,
    input  logic               dec_req,
    input  logic [127:0]       dec_data,
    input  logic [NK*32-1:0]   dec_key,
    output logic               dec_ack,
    output logic               dec_done,
    output logic [127:0]       result,
    output logic               busy,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso,
    output logic               cs_enc_n,
    output logic               cs_dec_n
);

    localparam int FRAME = 128 + NK*32;
    localparam int HW    = $clog2(DIV) + 1;
    localparam int BW    = $clog2(FRAME) + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TX   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RX   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic             ptr_dec;
    logic             side;
    logic [FRAME-1:0] tx_sr;
    logic [127:0]     rx_sr;
    logic [HW-1:0]    hcnt;
    logic [BW-1:0]    bcnt;
    logic             ph;
    logic             gnt_enc;
    logic             gnt_dec;
    logic             tick;

    // ptr_dec=1 means decrypt wins the next tie
    assign gnt_enc = enc_req && (!dec_req || !ptr_dec);
    assign gnt_dec = dec_req && (!enc_req || ptr_dec);
    assign tick    = (hcnt == '0);

    // ph keeps toggling through WAIT to time the gap, but sclk is only exposed in TX/RX
    assign sclk = ph && (state == S_TX || state == S_RX);
    assign mosi = (state == S_TX) ? tx_sr[FRAME-1] : 1'b0;
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            ptr_dec  <= 1'b0;
            side     <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            hcnt     <= '0;
            bcnt     <= '0;
            ph       <= 1'b0;
            cs_enc_n <= 1'b1;
            cs_dec_n <= 1'b1;
            enc_ack  <= 1'b0;
            dec_ack  <= 1'b0;
            enc_done <= 1'b0;
            dec_done <= 1'b0;
            result   <= '0;
        end else begin
            enc_ack  <= 1'b0;
            dec_ack  <= 1'b0;
            enc_done <= 1'b0;
            dec_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gnt_enc || gnt_dec) begin
                        side     <= gnt_dec;
                        enc_ack  <= gnt_enc;
                        dec_ack  <= gnt_dec;
                        tx_sr    <= gnt_dec ? {dec_data, dec_key} : {enc_data, enc_key};
                        cs_enc_n <= !gnt_enc;
                        cs_dec_n <= !gnt_dec;
                        if (enc_req && dec_req)
                            ptr_dec <= !ptr_dec;
                        hcnt     <= HW'(DIV - 1);
                        ph       <= 1'b0;
                        bcnt     <= BW'(FRAME - 1);
                        state    <= S_TX;
                    end
                end
                S_TX, S_WAIT, S_RX: begin
                    if (tick) begin
                        hcnt <= HW'(DIV - 1);
                        ph   <= !ph;
                        if (!ph && state == S_RX)
                            rx_sr <= {rx_sr[126:0], miso};
                        if (ph) begin
                            if (bcnt == '0) begin
                                case (state)
                                    S_TX: begin
                                        bcnt  <= BW'(WAIT_CYC - 1);
                                        state <= S_WAIT;
                                    end
                                    S_WAIT: begin
                                        bcnt  <= BW'(127);
                                        state <= S_RX;
                                    end
                                    default: begin
                                        cs_enc_n <= 1'b1;
                                        cs_dec_n <= 1'b1;
                                        state    <= S_DONE;
                                    end
                                endcase
                            end else begin
                                bcnt <= bcnt - BW'(1);
                                if (state == S_TX)
                                    tx_sr <= {tx_sr[FRAME-2:0], 1'b0};
                            end
                        end
                    end else begin
                        hcnt <= hcnt - HW'(1);
                    end
                end
                S_DONE: begin
                    result   <= rx_sr;
                    enc_done <= !side;
                    dec_done <= side;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
